demux_1x2_buffered: RTL and testbench

Buffered 1-to-2 distributor. It is the fan-out counterpart of the 2x1 mux in the NoC switch fabric. A single valid/ready input stream is routed by command to the low branch, the high branch, both (multicast), or discarded. Each branch has a 2-entry output buffer, so upstream backpressure is registered and does not depend on the downstream ready signals in the same cycle.

---
 rtl/noc_demux_pkg.sv | 17 +
 rtl/buffer_2entry_vr.sv | 44 ++++
 rtl/demux_1x2_buffered.sv | 60 ++++++
 tb/tb_demux_1x2_buffered.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/noc_demux_pkg.sv
// Shared route-command encodings and branch indices for the NoC demux fabric.
package noc_demux_pkg;

  localparam logic [1:0] CMD_DROP = 2'b00;
  localparam logic [1:0] CMD_LOW  = 2'b01;
  localparam logic [1:0] CMD_HIGH = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  localparam logic BRANCH_LOW  = 1'b0;
  localparam logic BRANCH_HIGH = 1'b1;

  // Each command bit selects one branch, so multicast is simply both bits set.
  function automatic logic routes_to(input logic [1:0] cmd, input logic branch);
    return cmd[branch];
  endfunction

endpackage

// File: rtl/buffer_2entry_vr.sv
// Two-entry FIFO for one output branch; head data reads as zero when empty.
module buffer_2entry_vr #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  rd_ptr;
  logic                  wr_idx;
  logic                  do_pop;

  assign head_valid = (count != 2'd0);
  assign do_pop     = pop & head_valid;
  // With at most two entries, write index = rd_ptr + count mod 2.
  assign wr_idx     = rd_ptr ^ count[0];
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
    end else begin
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (do_pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/demux_1x2_buffered.sv
// Buffered 1-to-2 distributor: routes one valid/ready stream to low, high, both or drop.
module demux_1x2_buffered
  import noc_demux_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COMMAND_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [COMMAND_WIDTH-1:0] i_cmd,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_bus,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  input  logic [1:0]              i_ready
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
  // o_ready comes only from i_en, i_cmd and registered counts, never from i_ready.
  logic [1:0] cnt_low, cnt_high;
  logic       room_low, room_high;
  logic       accept;
  logic       push_low, push_high;

  assign room_low  = (cnt_low  != 2'd2);
  assign room_high = (cnt_high != 2'd2);

  assign o_ready = i_en
                 & (~routes_to(i_cmd, BRANCH_LOW)  | room_low)
                 & (~routes_to(i_cmd, BRANCH_HIGH) | room_high);

  assign accept    = i_valid & o_ready;
  assign push_low  = accept & routes_to(i_cmd, BRANCH_LOW);
  assign push_high = accept & routes_to(i_cmd, BRANCH_HIGH);

  buffer_2entry_vr #(.DATA_WIDTH(DATA_WIDTH)) u_buf_low (
    .clk        (clk),
    .rst        (rst),
    .push       (push_low),
    .push_data  (i_data_bus),
    .pop        (i_ready[BRANCH_LOW]),
    .count      (cnt_low),
    .head_valid (o_valid[BRANCH_LOW]),
    .head_data  (o_data_bus[DATA_WIDTH-1:0])
  );

  buffer_2entry_vr #(.DATA_WIDTH(DATA_WIDTH)) u_buf_high (
    .clk        (clk),
    .rst        (rst),
    .push       (push_high),
    .push_data  (i_data_bus),
    .pop        (i_ready[BRANCH_HIGH]),
    .count      (cnt_high),
    .head_valid (o_valid[BRANCH_HIGH]),
    .head_data  (o_data_bus[DATA_WIDTH+:DATA_WIDTH])
  );

endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Self-checking bench for demux_1x2_buffered: per-branch expected queues, directed and random traffic.
module tb_demux_1x2_buffered;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_en;
  logic [1:0]      i_cmd;
  logic            i_valid;
  logic [DW-1:0]   i_data_bus;
  logic            o_ready;
  logic [1:0]      o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [1:0]      i_ready;

  logic [DW-1:0] exp_q_low[$];
  logic [DW-1:0] exp_q_high[$];
  int checks = 0;
  int errors = 0;

  demux_1x2_buffered #(.DATA_WIDTH(DW), .COMMAND_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] cmd, input logic v,
                       input logic [DW-1:0] d, input logic [1:0] rdy);
    i_en       = en;
    i_cmd      = cmd;
    i_valid    = v;
    i_data_bus = d;
    i_ready    = rdy;
  endtask

  // Called just after a falling edge with inputs applied: check outputs against
  // the scoreboard, retire pops, record accepts, then advance to the next falling edge.
  task automatic step();
    int   szl;
    int   szh;
    logic exp_rdy;
    #1;
    szl = exp_q_low.size();
    szh = exp_q_high.size();
    exp_rdy = i_en & (~i_cmd[0] | (szl < 2)) & (~i_cmd[1] | (szh < 2));
    check_eq("o_ready", {63'd0, o_ready}, {63'd0, exp_rdy});
    check_eq("o_valid", {62'd0, o_valid}, {62'd0, szh != 0, szl != 0});
    if (!o_valid[0]) check_eq("low_dummy", {32'd0, o_data_bus[DW-1:0]}, 64'd0);
    if (!o_valid[1]) check_eq("high_dummy", {32'd0, o_data_bus[DW+:DW]}, 64'd0);
    if (o_valid[0] && i_ready[0] && szl != 0)
      check_eq("low_data", {32'd0, o_data_bus[DW-1:0]}, {32'd0, exp_q_low.pop_front()});
    if (o_valid[1] && i_ready[1] && szh != 0)
      check_eq("high_data", {32'd0, o_data_bus[DW+:DW]}, {32'd0, exp_q_high.pop_front()});
    if (i_valid && exp_rdy) begin
      if (i_cmd[0]) exp_q_low.push_back(i_data_bus);
      if (i_cmd[1]) exp_q_high.push_back(i_data_bus);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, '0, 2'b00);
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {62'd0, o_valid}, 64'd0);
    check_eq("rst_data", o_data_bus, 64'd0);
    rst = 1'b0;

    // Route low, then the pop empties it.
    drive(1'b1, 2'b01, 1'b1, 32'hAAAAAAAA, 2'b11); step();
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); step(); step();

    // Multicast fills both branches; only drop remains acceptable.
    drive(1'b1, 2'b11, 1'b1, 32'hFFFFFFFF, 2'b00); step(); step();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c[1:0], 1'b0, '0, 2'b00); step();
    end
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); repeat (3) step();

    // High held full while low streams; high frees one slot after a single pop.
    drive(1'b1, 2'b10, 1'b1, $urandom, 2'b01); step(); step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b01, 1'b1, $urandom, 2'b01); step();
    end
    drive(1'b1, 2'b10, 1'b1, 32'h0000BEEF, 2'b01); repeat (3) step();
    drive(1'b1, 2'b10, 1'b1, 32'h0000BEEF, 2'b11); step();
    drive(1'b1, 2'b10, 1'b1, 32'h0000BEEF, 2'b01); step();
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); repeat (4) step();

    // Drop consumes without output; disable blocks input while buffers drain.
    drive(1'b1, 2'b00, 1'b1, $urandom, 2'b00); repeat (3) step();
    drive(1'b1, 2'b11, 1'b1, 32'h11111111, 2'b00); step();
    drive(1'b1, 2'b11, 1'b1, 32'h22222222, 2'b00); step();
    drive(1'b0, 2'b11, 1'b1, 32'h33333333, 2'b11); repeat (4) step();

    // Push while popping at count 1 keeps order 1,2,3.
    drive(1'b1, 2'b01, 1'b1, 32'd1, 2'b00); step();
    drive(1'b1, 2'b01, 1'b1, 32'd2, 2'b01); step();
    drive(1'b1, 2'b01, 1'b1, 32'd3, 2'b01); step();
    drive(1'b1, 2'b00, 1'b0, '0, 2'b01); repeat (3) step();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, 2'($urandom_range(0, 3)));
      step();
    end
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); repeat (4) step();

    // Asynchronous reset with both branches full.
    drive(1'b1, 2'b11, 1'b1, 32'hCAFEF00D, 2'b00); step();
    drive(1'b1, 2'b11, 1'b1, 32'hDEADBEEF, 2'b00); step();
    drive(1'b1, 2'b00, 1'b0, '0, 2'b00);
    check_eq("full_before_rst", {62'd0, o_valid}, 64'd3);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {62'd0, o_valid}, 64'd0);
    check_eq("async_rst_data", o_data_bus, 64'd0);
    exp_q_low.delete();
    exp_q_high.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); step();
    drive(1'b1, 2'b01, 1'b1, 32'h12345678, 2'b11); step();
    drive(1'b1, 2'b00, 1'b0, '0, 2'b11); repeat (2) step();

    check_eq("low_q_empty", 64'(exp_q_low.size()), 64'd0);
    check_eq("high_q_empty", 64'(exp_q_high.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
